aes_result_display: RTL and testbench

- Downstream consumer of the AES encrypt core.
- Issues a one-cycle load request to the encryptor and waits for its valid strobe.
- Captures the 128-bit ciphertext and presents it one 32-bit word at a time on the seven-segment LED bus.
- A debounced pushbutton steps through the words.
- Replaces the ad-hoc button/display logic in the board top level with a clean, fully synchronous block.

---
 rtl/aes_result_display.sv | 173 +++++++++++++++++
 tb/tb_aes_result_display.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/aes_result_display.sv
// aes_result_display
//   Sits downstream of the AES encrypt core. On a start request it pulses
//   the encryptor's load input for one cycle. It then waits for the valid
//   strobe and captures the 128-bit ciphertext. The captured block is shown
//   one 32-bit word at a time on the seven-segment LED bus. A debounced,
//   active-low pushbutton steps through the four words.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   btn      in   raw pushbutton, active-low, asynchronous to clk
//   start    in   request a new encryption (level, sampled every cycle)
//   load     out  one-cycle pulse to the encryptor's load input
//   valid    in   encryptor result strobe; ct is valid while high
//   ct       in   ciphertext from the encryptor (BLK_W bits)
//   busy     out  high while a load is issued or a result is awaited
//   word_idx out  index of the word currently displayed (0 = ct[127:96])
//   seg_led  out  displayed ciphertext word (WORD_W bits)
//
// All outputs are driven straight from flops, so there is no combinational
// path from any input to any output. BLK_W must equal 4*WORD_W, and
// DB_CYCLES must be at least 2.
module aes_result_display #(
  parameter int DB_CYCLES = 1000,
  parameter int BLK_W     = 128,
  parameter int WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic              start,
  output logic              load,
  input  logic              valid,
  input  logic [BLK_W-1:0]  ct,
  output logic              busy,
  output logic [1:0]        word_idx,
  output logic [WORD_W-1:0] seg_led
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  // The counter clears in the same cycle it would reach DB_CYCLES, so the
  // last value it ever holds is DB_CYCLES-1.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // ------------------------------------------------------------------
  // Button path: 2-flop synchronizer, level debouncer, press detector
  // ------------------------------------------------------------------
  logic             btn_meta_reg;
  logic             btn_s_reg;
  logic             btn_db_reg;
  logic             press_reg;
  logic [CNT_W-1:0] db_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_reg <= 1'b1;
      btn_s_reg    <= 1'b1;
      btn_db_reg   <= 1'b1;
      db_cnt_reg   <= '0;
      press_reg    <= 1'b0;
    end else begin
      btn_meta_reg <= btn;
      btn_s_reg    <= btn_meta_reg;
      press_reg    <= 1'b0;
      if (btn_s_reg == btn_db_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
        // The new level has been stable long enough, so accept it.
        // Only the release->press edge (1->0) raises an event.
        btn_db_reg <= btn_s_reg;
        db_cnt_reg <= '0;
        press_reg  <= ~btn_s_reg;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Captured ciphertext, split into display words (word 0 = MS word)
  // ------------------------------------------------------------------
  logic [BLK_W-1:0]  ct_q_reg;
  logic [WORD_W-1:0] ct_words [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_words
      assign ct_words[gi] = ct_q_reg[BLK_W-1-WORD_W*gi -: WORD_W];
    end
  endgenerate

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  logic capture;
  logic advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      S_IDLE: if (start) state_next = S_LOAD;
      S_LOAD: state_next = S_WAIT;
      S_WAIT: begin
        if (valid) begin
          capture    = 1'b1;
          state_next = S_SHOW;
        end
      end
      S_SHOW: begin
        // start has priority: a coincident press is dropped.
        if (start)          state_next = S_LOAD;
        else if (press_reg) advance    = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Registered outputs
  // ------------------------------------------------------------------
  logic              load_reg;
  logic              busy_reg;
  logic [1:0]        word_idx_reg;
  logic [1:0]        word_idx_inc;
  logic [WORD_W-1:0] seg_led_reg;

  assign word_idx_inc = word_idx_reg + 2'd1;  // wraps 3 -> 0

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      ct_q_reg     <= '0;
      word_idx_reg <= '0;
      seg_led_reg  <= '0;
    end else begin
      // Decoded from the next state so load/busy line up with the state.
      load_reg <= (state_next == S_LOAD);
      busy_reg <= (state_next == S_LOAD) || (state_next == S_WAIT);
      if (capture) begin
        ct_q_reg     <= ct;
        word_idx_reg <= 2'd0;
        seg_led_reg  <= ct[BLK_W-1 -: WORD_W];
      end else if (advance) begin
        word_idx_reg <= word_idx_inc;
        seg_led_reg  <= ct_words[word_idx_inc];
      end
      // In all other cases the display holds. IDLE is only reachable
      // through reset, so the display is already zero there.
    end
  end

  assign load     = load_reg;
  assign busy     = busy_reg;
  assign word_idx = word_idx_reg;
  assign seg_led  = seg_led_reg;

endmodule

// File: tb/tb_aes_result_display.sv
module tb_aes_result_display;

  localparam logic [127:0] CT1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] CT2 = 128'hdeadbeef_01234567_89abcdef_fedcba98;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn;
  logic         start;
  logic         load;
  logic         valid;
  logic [127:0] ct;
  logic         busy;
  logic [1:0]   word_idx;
  logic [31:0]  seg_led;

  int errors = 0;
  int checks = 0;

  aes_result_display #(.DB_CYCLES(4), .BLK_W(128), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .btn(btn), .start(start), .load(load),
    .valid(valid), .ct(ct), .busy(busy), .word_idx(word_idx),
    .seg_led(seg_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         start;
    logic         valid;
    logic [127:0] ct;
    logic         exp_load;
    logic         exp_busy;
    logic [1:0]   exp_idx;
    logic [31:0]  exp_seg;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic el, input logic eb,
                           input logic [1:0] ei, input logic [31:0] es);
    check({name, ".load"}, {31'd0, load}, {31'd0, el});
    check({name, ".busy"}, {31'd0, busy}, {31'd0, eb});
    check({name, ".idx"},  {30'd0, word_idx}, {30'd0, ei});
    check({name, ".seg"},  seg_led, es);
    $display("txn %-14s load=%b busy=%b idx=%0d seg=%h", name, load, busy, word_idx, seg_led);
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_btn(input logic v, input int n);
    btn = v;
    repeat (n) step();
  endtask

  initial begin
    // {name, start, valid, ct, exp_load, exp_busy, exp_idx, exp_seg}
    vecs[0] = '{"idle",         1'b0, 1'b0, 128'd0, 1'b0, 1'b0, 2'd0, 32'h00000000};
    vecs[1] = '{"valid_idle",   1'b0, 1'b1, CT2,    1'b0, 1'b0, 2'd0, 32'h00000000};
    vecs[2] = '{"start",        1'b1, 1'b0, 128'd0, 1'b1, 1'b1, 2'd0, 32'h00000000};
    vecs[3] = '{"wait",         1'b0, 1'b0, 128'd0, 1'b0, 1'b1, 2'd0, 32'h00000000};
    vecs[4] = '{"start_wait",   1'b1, 1'b0, 128'd0, 1'b0, 1'b1, 2'd0, 32'h00000000};
    vecs[5] = '{"capture",      1'b0, 1'b1, CT1,    1'b0, 1'b0, 2'd0, 32'h00112233};
    vecs[6] = '{"valid_show",   1'b0, 1'b1, CT2,    1'b0, 1'b0, 2'd0, 32'h00112233};
    vecs[7] = '{"restart",      1'b1, 1'b0, 128'd0, 1'b1, 1'b1, 2'd0, 32'h00112233};
    vecs[8] = '{"valid_load",   1'b0, 1'b1, CT2,    1'b0, 1'b1, 2'd0, 32'h00112233};

    rst = 1'b1; btn = 1'b1; start = 1'b0; valid = 1'b0; ct = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    step();
    check_all("reset", 1'b0, 1'b0, 2'd0, 32'h0);

    for (int i = 0; i < 9; i++) begin
      start = vecs[i].start;
      valid = vecs[i].valid;
      ct    = vecs[i].ct;
      step();
      check_all(vecs[i].name, vecs[i].exp_load, vecs[i].exp_busy,
                vecs[i].exp_idx, vecs[i].exp_seg);
    end

    // Now in WAIT after the stray valid during LOAD; capture CT1 again.
    start = 1'b0; valid = 1'b1; ct = CT1;
    step();
    check_all("recapture", 1'b0, 1'b0, 2'd0, 32'h00112233);
    valid = 1'b0; ct = '0;

    // Four clean presses step through the words and wrap.
    begin
      logic [31:0] exp_w [4];
      exp_w[0] = 32'h44556677; exp_w[1] = 32'h8899aabb;
      exp_w[2] = 32'hccddeeff; exp_w[3] = 32'h00112233;
      for (int p = 0; p < 4; p++) begin
        hold_btn(1'b0, 10);
        hold_btn(1'b1, 10);
        check_all($sformatf("press%0d", p), 1'b0, 1'b0, 2'((p + 1) % 4), exp_w[p]);
      end
    end

    // Bounce: low 3, high 1, then held low -> exactly one step.
    hold_btn(1'b0, 3);
    hold_btn(1'b1, 1);
    hold_btn(1'b0, 12);
    hold_btn(1'b1, 10);
    check_all("bounce", 1'b0, 1'b0, 2'd1, 32'h44556677);

    // A 3-cycle low glitch is shorter than the debounce window.
    hold_btn(1'b0, 3);
    hold_btn(1'b1, 10);
    check_all("glitch", 1'b0, 1'b0, 2'd1, 32'h44556677);

    // One more press to reach word 2.
    hold_btn(1'b0, 10);
    hold_btn(1'b1, 10);
    check_all("to_idx2", 1'b0, 1'b0, 2'd2, 32'h8899aabb);

    // Asynchronous reset in the middle of a cycle.
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 2'd0, 32'h0);
    #2 rst = 1'b0;

    // valid alone after reset is ignored.
    valid = 1'b1; ct = CT2;
    step();
    step();
    check_all("valid_after_rst", 1'b0, 1'b0, 2'd0, 32'h0);

    // A fresh transaction captures CT2.
    valid = 1'b0; start = 1'b1;
    step();
    check_all("start2", 1'b1, 1'b1, 2'd0, 32'h0);
    start = 1'b0;
    step();
    check_all("wait2", 1'b0, 1'b1, 2'd0, 32'h0);
    valid = 1'b1;
    step();
    check_all("capture2", 1'b0, 1'b0, 2'd0, 32'hdeadbeef);
    valid = 1'b0;
    hold_btn(1'b0, 10);
    hold_btn(1'b1, 10);
    check_all("press_ct2", 1'b0, 1'b0, 2'd1, 32'h01234567);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
